// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sizes, bank state encoding and the
// bit-reversal helper used by the output reorder stage.
package fft_pkg;

  localparam int FFT_WIDTH = 12;
  localparam int FFT_N     = 16;
  localparam int MAX_LOGN  = 10;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_state_t;

  // Reverses the low nbits bits of v; bits above nbits come back as zero.
  function automatic logic [MAX_LOGN-1:0] bitrev(input logic [MAX_LOGN-1:0] v,
                                                 input int nbits);
    logic [MAX_LOGN-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_LOGN; i++) begin
      if (i < nbits) r[i] = v[nbits-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_output_reorder_ram.sv
// Simple dual-port RAM for one half of one reorder bank: one write port,
// one read port with a registered output that holds while re is low.
module reorder_ram
  import fft_pkg::*;
#(
  parameter int width = FFT_WIDTH,
  parameter int DEPTH = FFT_N / 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [width-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [width-1:0] rdata
);

  logic [width-1:0] mem [DEPTH];
  logic [width-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_reg <= mem[raddr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/fft_output_reorder.sv
// Converts bit-reversed two-line FFT output into a natural-order serial
// stream through a ping-pong buffer. Optional status ports: FFT_REORDER_STATUS_EN.
module fft_output_reorder
  import fft_pkg::*;
#(
  parameter int width = FFT_WIDTH,
  parameter int N     = FFT_N
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] line1,
  input  logic [width-1:0] line2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic             out_last
`ifdef FFT_REORDER_STATUS_EN
  ,
  output logic [15:0]      frames_out,
  output logic [0:0]       drop_err
`endif
);

  localparam int LOGN = $clog2(N);
  localparam int HALF = N / 2;
  localparam int AW   = LOGN - 1;
  localparam logic [AW-1:0]   W_LAST = AW'(HALF - 1);
  localparam logic [LOGN-1:0] K_LAST = LOGN'(N - 1);

  // Write side
  logic            wr_bank_reg, wr_bank_next;
  logic [AW-1:0]   wr_cnt_reg, wr_cnt_next;
  logic            in_ready_reg, in_ready_next;
  logic [AW-1:0]   wr_addr;
  bank_state_t     state_reg [2];
  bank_state_t     state_next [2];

  // Read side: iss_bank follows address issue, rd_bank follows output transfers
  logic            iss_bank_reg, iss_bank_next;
  logic            rd_bank_reg, rd_bank_next;
  logic [LOGN-1:0] rd_cnt_reg, rd_cnt_next;
  logic            rd_pend_reg, rd_pend_next;
  logic [1:0]      pend_sel_reg, pend_sel_next;
  logic            pend_last_reg, pend_last_next;
  logic            out_valid_reg, out_valid_next;
  logic [width-1:0] out_data_reg, out_data_next;
  logic            out_last_reg, out_last_next;

  logic            wr_fire, out_fire, slot_free, readable, issue, load;
  logic [3:0]      ram_we, ram_re;
  logic [width-1:0] ram_rdata [4];

  assign wr_fire   = in_valid & in_ready_reg;
  assign out_fire  = out_valid_reg & out_ready;
  assign slot_free = ~out_valid_reg | out_ready;
  // A new frame may start only from a FULL bank; mid-frame issue always continues.
  assign readable  = (rd_cnt_reg == '0) ? (state_reg[iss_bank_reg] == FULL) : 1'b1;
  assign issue     = readable & slot_free;
  assign load      = rd_pend_reg & slot_free;
  assign wr_addr   = AW'(bitrev(MAX_LOGN'({wr_cnt_reg, 1'b0}), LOGN));

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ram
      logic [width-1:0] wdata;
      if ((gi & 1) == 1) begin : g_hi
        assign wdata = line2;
      end else begin : g_lo
        assign wdata = line1;
      end
      assign ram_we[gi] = wr_fire & (wr_bank_reg == 1'(gi >> 1));
      assign ram_re[gi] = issue & (iss_bank_reg == 1'(gi >> 1))
                        & (rd_cnt_reg[LOGN-1] == 1'(gi & 1));
      reorder_ram #(
        .width(width),
        .DEPTH(HALF)
      ) u_ram (
        .clk  (clk),
        .we   (ram_we[gi]),
        .waddr(wr_addr),
        .wdata(wdata),
        .re   (ram_re[gi]),
        .raddr(rd_cnt_reg[AW-1:0]),
        .rdata(ram_rdata[gi])
      );
    end

    for (gi = 0; gi < 2; gi++) begin : g_bank
      always_comb begin
        state_next[gi] = state_reg[gi];
        case (state_reg[gi])
          EMPTY: begin
            if (wr_fire && wr_bank_reg == 1'(gi)) state_next[gi] = FILLING;
          end
          FILLING: begin
            if (wr_fire && wr_bank_reg == 1'(gi) && wr_cnt_reg == W_LAST)
              state_next[gi] = FULL;
          end
          FULL: begin
            if (issue && iss_bank_reg == 1'(gi)) state_next[gi] = DRAINING;
          end
          DRAINING: begin
            if (out_fire && out_last_reg && rd_bank_reg == 1'(gi))
              state_next[gi] = EMPTY;
          end
          default: state_next[gi] = EMPTY;
        endcase
      end
    end
  endgenerate

  always_comb begin
    wr_cnt_next  = wr_cnt_reg;
    wr_bank_next = wr_bank_reg;
    if (wr_fire) begin
      if (wr_cnt_reg == W_LAST) begin
        wr_cnt_next  = '0;
        wr_bank_next = ~wr_bank_reg;
      end else begin
        wr_cnt_next = wr_cnt_reg + 1'b1;
      end
    end
    in_ready_next = (state_next[wr_bank_next] == EMPTY)
                  | (state_next[wr_bank_next] == FILLING);
  end

  always_comb begin
    rd_cnt_next    = rd_cnt_reg;
    iss_bank_next  = iss_bank_reg;
    pend_sel_next  = pend_sel_reg;
    pend_last_next = pend_last_reg;
    rd_pend_next   = issue | (rd_pend_reg & ~load);
    if (issue) begin
      rd_cnt_next    = rd_cnt_reg + 1'b1;
      pend_sel_next  = {iss_bank_reg, rd_cnt_reg[LOGN-1]};
      pend_last_next = (rd_cnt_reg == K_LAST);
      if (rd_cnt_reg == K_LAST) iss_bank_next = ~iss_bank_reg;
    end

    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_last_next  = out_last_reg;
    if (load) begin
      out_valid_next = 1'b1;
      out_data_next  = ram_rdata[pend_sel_reg];
      out_last_next  = pend_last_reg;
    end else if (out_fire) begin
      out_valid_next = 1'b0;
    end

    rd_bank_next = rd_bank_reg;
    if (out_fire && out_last_reg) rd_bank_next = ~rd_bank_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank_reg   <= 1'b0;
      wr_cnt_reg    <= '0;
      in_ready_reg  <= 1'b0;
      state_reg[0]  <= EMPTY;
      state_reg[1]  <= EMPTY;
      iss_bank_reg  <= 1'b0;
      rd_bank_reg   <= 1'b0;
      rd_cnt_reg    <= '0;
      rd_pend_reg   <= 1'b0;
      pend_sel_reg  <= '0;
      pend_last_reg <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
    end else begin
      wr_bank_reg   <= wr_bank_next;
      wr_cnt_reg    <= wr_cnt_next;
      in_ready_reg  <= in_ready_next;
      state_reg[0]  <= state_next[0];
      state_reg[1]  <= state_next[1];
      iss_bank_reg  <= iss_bank_next;
      rd_bank_reg   <= rd_bank_next;
      rd_cnt_reg    <= rd_cnt_next;
      rd_pend_reg   <= rd_pend_next;
      pend_sel_reg  <= pend_sel_next;
      pend_last_reg <= pend_last_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_last_reg  <= out_last_next;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;

`ifdef FFT_REORDER_STATUS_EN
  logic [15:0] frames_out_reg;
  logic        drop_err_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      frames_out_reg <= '0;
      drop_err_reg   <= 1'b0;
    end else begin
      if (out_fire && out_last_reg) frames_out_reg <= frames_out_reg + 16'd1;
      if (in_valid && !in_ready_reg) drop_err_reg <= 1'b1;
    end
  end

  assign frames_out = frames_out_reg;
  assign drop_err   = drop_err_reg;
`endif

endmodule

// File: tb/tb_fft_output_reorder.sv
// Scoreboard bench for fft_output_reorder (N=16, width=12): stimulus pushes
// natural-order expectations, a negedge monitor pops on every output transfer.
module tb_fft_output_reorder;

  localparam int W  = 12;
  localparam int NP = 16;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] line1;
  logic [W-1:0] line2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
`ifdef FFT_REORDER_STATUS_EN
  logic [15:0]  frames_out;
  logic [0:0]   drop_err;
`endif

  always #5 clk = ~clk;

  fft_output_reorder #(
    .width(W),
    .N    (NP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .line1    (line1),
    .line2    (line2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
`ifdef FFT_REORDER_STATUS_EN
    ,
    .frames_out(frames_out),
    .drop_err  (drop_err)
`endif
  );

  exp_t         sb[$];
  exp_t         mon_e;
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           pop_cyc[$];
  int           ready_low_cnt = 0;
  logic [W-1:0] frame_x [NP];
  int           br [NP/2] = '{0, 4, 2, 6, 1, 5, 3, 7};

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every output transfer is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: got data=%0d last=%0b, nothing expected",
                 $signed(out_data), out_last);
      end else begin
        mon_e = sb.pop_front();
        if (out_data !== mon_e.d || out_last !== mon_e.l) begin
          bad++;
          $display("FAIL stream: got data=%0d last=%0b, want data=%0d last=%0b",
                   $signed(out_data), out_last, $signed(mon_e.d), mon_e.l);
        end
      end
      pop_cyc.push_back(cyc);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b);
    bit acc;
    int t;
    line1    = a;
    line2    = b;
    in_valid = 1'b1;
    t        = 0;
    do begin
      acc = in_ready;
      if (!acc) ready_low_cnt++;
      tick();
      t++;
    end while (!acc && t < 500);
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles, want 1", t);
    end
  endtask

  task automatic fill_frame(input int offset);
    for (int k = 0; k < NP; k++) frame_x[k] = W'(offset + k);
  endtask

  // Sends frame_x in bit-reversed pair order, then queues it in natural order.
  task automatic send_frame();
    for (int j = 0; j < NP/2; j++) send_pair(frame_x[br[j]], frame_x[br[j] + NP/2]);
    for (int k = 0; k < NP; k++) sb.push_back(exp_t'{d: frame_x[k], l: (k == NP-1)});
    $display("sent frame x0=%0d x15=%0d", $signed(frame_x[0]), $signed(frame_x[NP-1]));
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || out_valid) && t < 2000) begin
      tick();
      t++;
    end
    if (sb.size() != 0 || out_valid) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d samples pending, want 0", sb.size());
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    line1     = '0;
    line2     = '0;

    // Reset state
    repeat (3) tick();
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_out_data", int'(out_data), 0);
    reset = 1'b0;
    tick();
    check("post_rst_in_ready", int'(in_ready), 1);

    // Basic reorder with latency check
    fill_frame(0);
    send_frame();
    in_valid = 1'b0;
    check("lat_edge0_valid", int'(out_valid), 0);
    tick();
    check("lat_edge1_valid", int'(out_valid), 0);
    tick();
    check("lat_edge2_valid", int'(out_valid), 1);
    check("lat_edge2_data", int'(out_data), 0);
    wait_drain();

    // Back-to-back frames
    pop_cyc.delete();
    ready_low_cnt = 0;
    for (int f = 0; f < 4; f++) begin
      fill_frame(16 * f);
      send_frame();
    end
    in_valid = 1'b0;
    wait_drain();
    check("b2b_count", pop_cyc.size(), 64);
    if (pop_cyc.size() == 64) check("b2b_span", pop_cyc[63] - pop_cyc[0], 63);
    check("b2b_backpressure", int'(ready_low_cnt > 0), 1);

    // Output stall at k=3
    fill_frame(100);
    send_frame();
    in_valid = 1'b0;
    t = 0;
    while (!(out_valid && out_data == W'(103)) && t < 200) begin
      tick();
      t++;
    end
    check("stall_reach_k3", int'(out_valid && out_data == W'(103)), 1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", int'(out_valid), 1);
      check("stall_data", int'(out_data), 103);
    end
    out_ready = 1'b1;
    wait_drain();

    // Reset mid-frame: the partial frame is never queued, so any leak mismatches
    fill_frame(200);
    for (int j = 0; j < 6; j++) send_pair(frame_x[br[j]], frame_x[br[j] + NP/2]);
    in_valid = 1'b0;
    reset    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_in_ready", int'(in_ready), 0);
    end
    reset = 1'b0;
    tick();
    fill_frame(0);
    send_frame();
    in_valid = 1'b0;
    wait_drain();

    // Signed extremes at positions 0 and 15
    fill_frame(0);
    frame_x[0]    = 12'h800;
    frame_x[NP-1] = 12'h7FF;
    send_frame();
    in_valid = 1'b0;
    wait_drain();

`ifdef FFT_REORDER_STATUS_EN
    do_reset();
    check("st_rst_frames", int'(frames_out), 0);
    for (int f = 0; f < 3; f++) begin
      fill_frame(16 * f);
      send_frame();
      in_valid = 1'b0;
      wait_drain();
    end
    check("st_frames3", int'(frames_out), 3);
    check("st_no_drop", int'(drop_err), 0);
    out_ready = 1'b0;
    fill_frame(500);
    send_frame();
    fill_frame(600);
    send_frame();
    in_valid = 1'b0;
    tick();
    check("st_blocked", int'(in_ready), 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("st_drop_set", int'(drop_err), 1);
    out_ready = 1'b1;
    wait_drain();
    check("st_drop_sticky", int'(drop_err), 1);
    check("st_frames5", int'(frames_out), 5);
    do_reset();
    check("st_drop_cleared", int'(drop_err), 0);
`else
    do_reset();
`endif

    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
